// File: rtl/alu_share_arb.sv
// Two-requester arbiter for the shared execute-stage ALU: grants one op per cycle,
// captures the ALU result in a one-entry slot and returns it over valid/ready.
module alu_share_arb #(
    parameter int XLEN       = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_y,
    output logic            rsp_err,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_y
);

    // Op encoding shared with the ALU; 4'hA..4'hF are illegal.
    localparam logic [3:0] EXE_ADD_OP  = 4'h0;
    localparam logic [3:0] EXE_SLTU_OP = 4'h9;

    logic            slot_full;
    logic            slot_owner;
    logic [XLEN-1:0] slot_y;
    logic            slot_err;
    logic            last_grant;

    logic drain;
    logic can_accept;
    logic any_req;
    logic grant;
    logic accept;
    logic op_legal;

    assign drain      = slot_full & (slot_owner ? rsp1_ready : rsp0_ready);
    assign can_accept = !slot_full | drain;
    assign any_req    = req0_valid | req1_valid;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = FIXED_PRIO ? 1'b0 : !last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    // Ready is gated by own valid so neither requester's ready depends on the other's.
    assign req0_ready = can_accept & !grant & req0_valid;
    assign req1_ready = can_accept &  grant & req1_valid;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        alu_op = EXE_ADD_OP;
        alu_a  = '0;
        alu_b  = '0;
        if (any_req) begin
            alu_op = grant ? req1_op : req0_op;
            alu_a  = grant ? req1_a  : req0_a;
            alu_b  = grant ? req1_b  : req0_b;
        end
    end

    assign op_legal = (alu_op <= EXE_SLTU_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full  <= 1'b0;
            slot_owner <= 1'b0;
            slot_y     <= '0;
            slot_err   <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            // Accept wins over drain: the slot is refilled in the same cycle it empties.
            slot_full  <= 1'b1;
            slot_owner <= grant;
            last_grant <= grant;
            slot_y     <= op_legal ? alu_y : '0;
            slot_err   <= !op_legal;
        end else if (drain) begin
            slot_full  <= 1'b0;
        end
    end

    assign rsp0_valid = slot_full & !slot_owner;
    assign rsp1_valid = slot_full &  slot_owner;
    assign rsp_y      = slot_y;
    assign rsp_err    = slot_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin instance and a fixed-priority
// instance, each driven by a small behavioural ALU.
module tb_alu_share_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural ALU; illegal codes give a distinctive value the arbiter must zero.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a ^ b;
            4'h3: return a | b;
            4'h4: return a & b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return $signed(a) >>> b[4:0];
            4'h8: return {31'd0, $signed(a) < $signed(b)};
            4'h9: return {31'd0, a < b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Round-robin instance signals
    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
    logic [3:0]  req0_op = 0, req1_op = 0, alu_op;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [31:0] rsp_y, alu_a, alu_b, alu_y;
    assign alu_y = alu_model(alu_op, alu_a, alu_b);

    // Fixed-priority instance signals
    logic        f_req0_valid = 0, f_req1_valid = 0, f_rsp0_ready = 0, f_rsp1_ready = 0;
    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp_err;
    logic [3:0]  f_req0_op = 0, f_req1_op = 0, f_alu_op;
    logic [31:0] f_req0_a = 0, f_req0_b = 0, f_req1_a = 0, f_req1_b = 0;
    logic [31:0] f_rsp_y, f_alu_a, f_alu_b, f_alu_y;
    assign f_alu_y = alu_model(f_alu_op, f_alu_a, f_alu_b);

    alu_share_arb #(.XLEN(32), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
    );

    alu_share_arb #(.XLEN(32), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(f_req0_op),
        .req0_a(f_req0_a), .req0_b(f_req0_b),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(f_req1_op),
        .req1_a(f_req1_a), .req1_b(f_req1_b),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready),
        .rsp_y(f_rsp_y), .rsp_err(f_rsp_err),
        .alu_op(f_alu_op), .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_y(f_alu_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_alu_op", alu_op, 0);
        rst_n = 1'b1;

        // Single ADD from requester 0
        @(negedge clk);
        req0_valid = 1; req0_op = 4'h0; req0_a = 5; req0_b = 7; rsp0_ready = 1;
        #1;
        chk("add_req0_ready", req0_ready, 1);
        chk("add_alu_a", alu_a, 5);
        @(negedge clk);
        req0_valid = 0;
        chk("add_rsp0_valid", rsp0_valid, 1);
        chk("add_rsp_y", rsp_y, 12);
        chk("add_rsp_err", rsp_err, 0);
        chk("add_rsp1_valid", rsp1_valid, 0);
        @(negedge clk);
        chk("add_drained", rsp0_valid, 0);

        // Round-robin stream; last grant was 0 so requester 1 goes first
        req0_valid = 1; req0_op = 4'h1; req0_a = 10; req0_b = 3;
        req1_valid = 1; req1_op = 4'h2; req1_a = 32'hF0; req1_b = 32'h0F;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req0_ready", req0_ready, (i % 2 == 1));
            chk("rr_req1_ready", req1_ready, (i % 2 == 0));
            if (i > 0) begin
                chk("rr_rsp1_valid", rsp1_valid, (i % 2 == 1));
                chk("rr_rsp_y", rsp_y, (i % 2 == 1) ? 32'hFF : 32'd7);
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        chk("rr_last_rsp0_valid", rsp0_valid, 1);
        chk("rr_last_rsp_y", rsp_y, 7);
        @(negedge clk);

        // SLT held under backpressure while requester 1 waits
        req0_valid = 1; req0_op = 4'h8; req0_a = 32'hFFFF_FFFF; req0_b = 1; rsp0_ready = 0;
        #1;
        chk("bp_req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'h0; req1_a = 2; req1_b = 3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp_y", rsp_y, 1);
            chk("bp_req1_ready", req1_ready, 0);
            @(negedge clk);
        end
        rsp0_ready = 1;
        #1;
        chk("bp_req1_ready_on_drain", req1_ready, 1);
        @(negedge clk);
        req1_valid = 0;
        chk("bp_rsp1_valid", rsp1_valid, 1);
        chk("bp_rsp0_valid_off", rsp0_valid, 0);
        chk("bp_rsp1_y", rsp_y, 5);
        @(negedge clk);

        // Illegal op from requester 1, left un-consumed
        req1_valid = 1; req1_op = 4'hF; req1_a = 3; req1_b = 4; rsp1_ready = 0;
        #1;
        chk("ill_req1_ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 0;
        chk("ill_rsp1_valid", rsp1_valid, 1);
        chk("ill_rsp_y", rsp_y, 0);
        chk("ill_rsp_err", rsp_err, 1);

        // Fixed-priority instance: requester 0 always wins
        f_req0_valid = 1; f_req0_op = 4'h3; f_req0_a = 32'hF0; f_req0_b = 32'h0F;
        f_req1_valid = 1; f_req1_op = 4'h4; f_req1_a = 32'hF0; f_req1_b = 32'hFF;
        f_rsp0_ready = 1; f_rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fp_req0_ready", f_req0_ready, 1);
            chk("fp_req1_ready", f_req1_ready, 0);
            if (i > 0) chk("fp_rsp_y", f_rsp_y, 32'hFF);
            @(negedge clk);
        end
        f_req0_valid = 0;
        #1;
        chk("fp_req1_ready_after", f_req1_ready, 1);
        @(negedge clk);
        f_req1_valid = 0;
        chk("fp_rsp1_valid", f_rsp1_valid, 1);
        chk("fp_rsp1_y", f_rsp_y, 32'hF0);

        // Asynchronous reset with the round-robin slot still full
        chk("pre_rst_rsp1_valid", rsp1_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp1_valid", rsp1_valid, 0);
        chk("arst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1; req0_op = 4'h0; req0_a = 1; req0_b = 1;
        req1_valid = 1; req1_op = 4'h0; req1_a = 2; req1_b = 2;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        chk("post_rst_req0_ready", req0_ready, 1);
        chk("post_rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        chk("post_rst_rsp0_valid", rsp0_valid, 1);
        chk("post_rst_rsp_y", rsp_y, 2);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Two-requester arbiter and sequencer for the single shared 32-bit ALU in the execute stage. The execute path is requester 0; the address/branch-compare helper is requester 1. It grants one request per cycle, drives the external ALU's operand and op inputs, registers the ALU result in a one-entry response slot, and returns the result to the granted requester over a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width; only 32 is supported (ALU width).
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = requester 0 always wins.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_op  in  4  ALU op code (EXE_*_OP encoding).
req0_a  in  XLEN  operand a.
req0_b  in  XLEN  operand b.
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
rsp0_valid  out  1  result for requester 0 available.
rsp0_ready  in  1  requester 0 consumes result.
rsp1_valid  out  1  result for requester 1 available.
rsp1_ready  in  1  requester 1 consumes result.
rsp_y  out  XLEN  result data, shared by both response channels.
rsp_err  out  1  the held result came from an op code that is not legal.
alu_op  out  4  to ALU op.
alu_a  out  XLEN  to ALU a.
alu_b  out  XLEN  to ALU b.
alu_y  in  XLEN  from ALU y (combinational).

Behaviour:
- State:
  - slot_full, slot_owner (1b), slot_y, slot_err.
  - last_grant (1b).
- Reset values: slot_full=0, slot_owner=0, slot_y=0, slot_err=0, last_grant=1, so requester 0 wins the first tie.
- Reset effect on outputs: rsp0_valid=rsp1_valid=0, rsp_y=0, rsp_err=0, req*_ready=0.
- Drain and capacity:
  - drain = slot_full & rspN_ready, where N = slot_owner.
  - can_accept = !slot_full | drain. Back-to-back issue is allowed when the slot empties in the same cycle.
- Grant, combinational:
  - Only req0_valid asserted: grant 0.
  - Only req1_valid asserted: grant 1.
  - Both asserted with FIXED_PRIO=0: grant !last_grant.
  - Both asserted with FIXED_PRIO=1: grant 0.
- Handshake:
  - reqN_ready = can_accept & (grant==N) & reqN_valid.
  - Requesters must hold op/a/b stable while valid and not ready.
  - reqN_ready never depends on the other requester's ready.
- ALU drive:
  - With a grant: alu_op/a/b come from the granted requester, combinationally.
  - With no grant: alu_op=EXE_ADD_OP, alu_a=0, alu_b=0, so no X propagates.
- On accept (rising edge):
  - slot_full=1, slot_owner=grant, last_grant=grant.
  - slot_y = alu_y, or 0 if the op is illegal.
  - slot_err = op not one of ADD/SUB/XOR/OR/AND/SLL/SRL/SRA/SLT/SLTU.
- Latency: result visible on rsp_y with rspN_valid=1 exactly 1 cycle after accept.
- Response: rspN_valid = slot_full & (slot_owner==N). rsp_y/rsp_err hold stable until the drain.
- Drain: on drain with no new accept, slot_full=0. On drain with an accept in the same cycle, the slot is overwritten with the new result and stays full (one result per cycle sustained).
- Backpressure: while the owner holds rspN_ready=0, both reqN_ready are 0. The other requester waits and is not granted early.
- Fairness: with FIXED_PRIO=0 and both requesters continuously valid with consumers ready, grants alternate 0,1,0,1. A waiting requester is served within 2 accepts.
- Illegal op: the request is still accepted and takes one slot. rsp_y=0, rsp_err=1.
- Shift ops: only b[4:0] matters, as the ALU defines. The arbiter does not alter operands.
- Reset mid-operation: asynchronous clear of the slot. A pending result is dropped and not re-issued. Requesters must re-present after reset.
- No combinational path from rspN_ready to rspN_valid. A path from rspN_ready to reqM_ready exists (via drain) and is permitted.

Test Plan:
- Reset release, req0 ADD a=5 b=7 with rsp0_ready=1 -> req0_ready in cycle 0; rsp0_valid, rsp_y=12, rsp_err=0 in cycle 1; rsp1_valid stays 0.
- Both valid every cycle, FIXED_PRIO=0, req0 SUB 10-3, req1 XOR 0xF0^0x0F, all rsp ready -> grants 0,1,0,1; rsp_y alternates 7,0xFF; one result per cycle.
- req0 SLT a=0xFFFFFFFF b=1, rsp0_ready=0 for 3 cycles, req1 valid -> rsp_y=1 held 3 cycles; req1_ready=0 throughout; req1 accepted in the cycle rsp0_ready rises; its result appears the next cycle.
- req1 op=4'hF (illegal) -> accepted; rsp1_valid=1, rsp_y=0, rsp_err=1.
- FIXED_PRIO=1, both valid for 4 cycles -> req0 granted all 4; req1_ready=0 until req0_valid drops.
- rst_n asserted while slot full (rsp1_valid=1) -> rsp1_valid=0 immediately (asynchronous); after release a both-valid tie is granted to requester 0.
